// File: rtl/nbit_decoder_scan.sv
// nbit_decoder_scan: registered N-to-2^N one-hot decoder with load, step and prescaled auto-scan of its code register
module nbit_decoder_scan #(
  parameter int N = 2,
  parameter int DIV = 4
) (
  input  logic           clock,
  input  logic           reset_,
  input  logic [N-1:0]   x,
  input  logic [1:0]     cmd,
  input  logic           en,
  output logic [2**N-1:0] z,
  output logic [N-1:0]   code,
  output logic           wrap
);
  localparam int ZW = 2**N;
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  typedef enum logic [1:0] {HOLD, LOAD, STEP, SCAN} cmd_t;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0] code_n;
  logic tick, wrap_n;
  cmd_t c;
  always_comb begin
    c = cmd_t'(cmd);
    tick = c == STEP || (c == SCAN && cnt == LAST);
    code_n = c == LOAD ? x : tick ? code + 1'b1 : code;
    cnt_n = (c == LOAD || tick) ? '0 : c == SCAN ? cnt + 1'b1 : cnt;
    wrap_n = tick && (&code);
  end
  // z decodes the next code so it lines up with code after the same edge
  always_ff @(posedge clock) begin
    if (!reset_) begin
      code <= '0;
      cnt <= '0;
      z <= '0;
      wrap <= 1'b0;
    end else begin
      code <= code_n;
      cnt <= cnt_n;
      z <= en ? ZW'(1) << code_n : '0;
      wrap <= wrap_n;
    end
  end
endmodule

// File: tb/tb_nbit_decoder_scan.sv
// tb_nbit_decoder_scan: directed self-checking bench over three parameterisations of the decoder
module tb_nbit_decoder_scan;
  localparam logic [1:0] HOLD = 2'b00, LOAD = 2'b01, STEP = 2'b10, SCAN = 2'b11;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  int compared = 0, mismatched = 0;
  logic ra, ea, wa; logic [1:0] ca, xa, codea; logic [3:0] za;
  logic rb, eb, wb; logic [1:0] cb; logic [2:0] xb, codeb; logic [7:0] zb;
  logic rc, ec, wc; logic [1:0] cc; logic xc, codec; logic [1:0] zc;
  nbit_decoder_scan #(.N(2), .DIV(4)) ua (.clock(clock), .reset_(ra), .x(xa), .cmd(ca), .en(ea), .z(za), .code(codea), .wrap(wa));
  nbit_decoder_scan #(.N(3), .DIV(1)) ub (.clock(clock), .reset_(rb), .x(xb), .cmd(cb), .en(eb), .z(zb), .code(codeb), .wrap(wb));
  nbit_decoder_scan #(.N(1), .DIV(1)) uc (.clock(clock), .reset_(rc), .x(xc), .cmd(cc), .en(ec), .z(zc), .code(codec), .wrap(wc));
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_a(input string tag, input logic [1:0] c, input logic [3:0] z, input logic w);
    chk({tag, ".code"}, 32'(codea), 32'(c));
    chk({tag, ".z"}, 32'(za), 32'(z));
    chk({tag, ".wrap"}, 32'(wa), 32'(w));
  endtask
  initial begin
    ra = 0; ca = LOAD; xa = 2'd3; ea = 1;
    rb = 0; cb = SCAN; xb = 0; eb = 1;
    rc = 0; cc = LOAD; xc = 0; ec = 1;
    tick(); chk_a("rst1", 0, 4'b0000, 0);
    tick(); chk_a("rst2", 0, 4'b0000, 0);
    ra = 1;
    tick(); chk_a("load3", 3, 4'b1000, 0);
    xa = 2; tick(); chk_a("load2", 2, 4'b0100, 0);
    ca = STEP;
    tick(); chk_a("step3", 3, 4'b1000, 0);
    tick(); chk_a("step0", 0, 4'b0001, 1);
    tick(); chk_a("step1", 1, 4'b0010, 0);
    ca = LOAD; xa = 0; tick(); chk_a("load0", 0, 4'b0001, 0);
    ca = SCAN;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk_a($sformatf("scan%0d", i), i >= 8 ? 2'd2 : i >= 4 ? 2'd1 : 2'd0,
            i >= 8 ? 4'b0100 : i >= 4 ? 4'b0010 : 4'b0001, 0);
    end
    for (int pass = 0; pass < 2; pass++) begin
      ea = pass == 0; ca = LOAD; xa = 0; tick();
      ca = SCAN;
      for (int i = 0; i < 2; i++) begin tick(); chk_a($sformatf("p%0d_s%0d", pass, i), 0, pass == 0 ? 4'b0001 : 4'b0000, 0); end
      ca = HOLD;
      for (int i = 0; i < 5; i++) begin tick(); chk_a($sformatf("p%0d_h%0d", pass, i), 0, pass == 0 ? 4'b0001 : 4'b0000, 0); end
      ca = SCAN;
      tick(); chk_a($sformatf("p%0d_r0", pass), 0, pass == 0 ? 4'b0001 : 4'b0000, 0);
      tick(); chk_a($sformatf("p%0d_r1", pass), 1, pass == 0 ? 4'b0010 : 4'b0000, 0);
    end
    ca = HOLD; ea = 1; tick(); chk_a("unblank", 1, 4'b0010, 0);
    rb = 1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("b_scan%0d.code", i), 32'(codeb), 32'(i));
      chk($sformatf("b_scan%0d.z", i), 32'(zb), 32'(1) << i);
      chk($sformatf("b_scan%0d.wrap", i), 32'(wb), 0);
    end
    rb = 0; tick();
    chk("b_rst.code", 32'(codeb), 0);
    chk("b_rst.z", 32'(zb), 0);
    chk("b_rst.wrap", 32'(wb), 0);
    rc = 1; xc = 0; tick(); chk("c_x0.z", 32'(zc), 32'b01);
    xc = 1; tick(); chk("c_x1.z", 32'(zc), 32'b10);
    xc = 0; tick(); chk("c_x0b.z", 32'(zc), 32'b01);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
